// File: rtl/oam_dma_arbiter.sv
// Memory-port arbiter between dzcpu and an OAM DMA engine.
// Idle CPU traffic passes straight through; a write to the DMA register starts a copy into OAM.
module oam_dma_arbiter #(
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter logic [15:0] OAM_BASE     = 16'hFE00,
    parameter int unsigned DMA_LEN      = 160
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [15:0] iCpuAddr,
    input  logic [7:0]  iCpuData,
    input  logic        iCpuWe,
    output logic [7:0]  oCpuData,
    input  logic [7:0]  iMemData,
    output logic [15:0] oMemAddr,
    output logic [7:0]  oMemData,
    output logic        oMemWe,
    output logic        oDmaBusy,
    output logic [7:0]  oDmaReg
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    localparam logic [7:0] LAST_INDEX = 8'(DMA_LEN - 1);

    state_t     state, nextState;
    logic [7:0] dmaReg;
    logic [7:0] index;
    logic [7:0] buffer;
    logic       regHit;
    logic       regWrite;

    assign regHit   = (iCpuAddr == DMA_REG_ADDR);
    assign regWrite = iCpuWe & regHit;
    assign oDmaReg  = dmaReg;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state  <= IDLE;
            dmaReg <= '0;
            index  <= '0;
            buffer <= '0;
        end else begin
            state <= nextState;
            if (state == RD) begin
                buffer <= iMemData;
            end
            // A register write restarts the copy from any state, overriding the index step.
            if (regWrite) begin
                dmaReg <= iCpuData;
                index  <= '0;
            end else if (state == WR && index != LAST_INDEX) begin
                index <= index + 8'd1;
            end
        end
    end

    always_comb begin
        nextState = state;
        oMemAddr  = iCpuAddr;
        oMemData  = iCpuData;
        oMemWe    = iCpuWe & ~regHit;
        oCpuData  = regHit ? dmaReg : iMemData;
        oDmaBusy  = 1'b0;

        unique case (state)
            IDLE: begin
                if (regWrite) begin
                    nextState = RD;
                end
            end
            RD: begin
                oMemAddr  = {dmaReg, index};
                oMemData  = buffer;
                oMemWe    = 1'b0;
                oCpuData  = regHit ? dmaReg : 8'hFF;
                oDmaBusy  = 1'b1;
                nextState = WR;
            end
            WR: begin
                oMemAddr  = OAM_BASE + {8'h00, index};
                oMemData  = buffer;
                oMemWe    = 1'b1;
                oCpuData  = regHit ? dmaReg : 8'hFF;
                oDmaBusy  = 1'b1;
                nextState = (index == LAST_INDEX) ? IDLE : RD;
            end
            default: nextState = IDLE;
        endcase

        if (regWrite) begin
            nextState = RD;
        end
    end

endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
Owns the single memory port between dzcpu and the memory/MMU fabric, and shares it with a Game Boy style OAM DMA engine.
- Idle: CPU accesses pass straight through.
- On a CPU write to the DMA register (0xFF46), the engine takes the bus and copies DMA_LEN bytes from {src,8'h00} to OAM_BASE.
- While the copy runs, the CPU is locked out of the memory port.

Parameters:
DMA_REG_ADDR, 16'hFF46, address of the DMA source/trigger register
OAM_BASE, 16'hFE00, destination base address
DMA_LEN, 160, bytes per transfer (1..256)

Ports:
iClock  in  1  clock
iReset  in  1  synchronous, active-high reset
iCpuAddr  in  16  CPU address (dzcpu oMCUAddr)
iCpuData  in  8  CPU write data
iCpuWe  in  1  CPU write enable
oCpuData  out  8  read data returned to CPU
iMemData  in  8  memory read data (combinational, same-cycle)
oMemAddr  out  16  memory address
oMemData  out  8  memory write data
oMemWe  out  1  memory write enable
oDmaBusy  out  1  high while DMA owns the bus
oDmaReg  out  8  current DMA source register value

Behaviour:
Reset:
- State IDLE; DMA register 0x00; index 0; byte buffer 0x00; oDmaBusy=0.
- Reset has priority over everything. A reset mid-transfer aborts immediately: no further memory writes from the next cycle.

States: IDLE, RD, WR.

IDLE:
- oMemAddr=iCpuAddr, oMemData=iCpuData, oMemWe=iCpuWe & (iCpuAddr!=DMA_REG_ADDR).
- oCpuData=iMemData, except oCpuData=DMA register when iCpuAddr==DMA_REG_ADDR.
- CPU write to DMA_REG_ADDR at edge T: the register latches iCpuData, index clears to 0, and the state is RD from T+1. This write is not forwarded to memory.

RD:
- oMemAddr={reg,index[7:0]}, oMemWe=0.
- iMemData is captured into the buffer at the end of the cycle.
- Next state is WR.

WR:
- oMemAddr=OAM_BASE+index, oMemData=buffer, oMemWe=1.
- If index==DMA_LEN-1, next state is IDLE; otherwise index+1 and next state is RD.

Timing:
- One byte takes 2 cycles; a full transfer takes 2*DMA_LEN cycles (320 by default).
- oDmaBusy=1 exactly in RD/WR, i.e. from T+1 through the final WR cycle.

CPU during RD/WR:
- Writes are dropped (never reach memory), except writes to DMA_REG_ADDR.
- Reads return 8'hFF, except DMA_REG_ADDR, which returns the register.

Restart:
- A CPU write to DMA_REG_ADDR during RD or WR reloads the register, clears the index, and forces RD next cycle.
- The WR beat in progress still completes in the current cycle with the old data.
- This overrides the end-of-transfer return to IDLE.

Arithmetic and wrap:
- Index is 8-bit; source address is {reg,index} with no carry out.
- Destination is the 16-bit sum OAM_BASE+index, modulo 2^16.
- Source values 0xE0–0xFF are used unmodified (no clamping).

Test Plan:
- Idle pass-through: CPU writes 0x5A to 0xC010 with iCpuWe=1 -> oMemAddr=0xC010, oMemData=0x5A, oMemWe=1, oDmaBusy=0. A subsequent read returns iMemData.
- Basic DMA: preload 0xC000–0xC09F with i^0x3C; CPU writes 0xC0 to 0xFF46 at edge T.
  - oDmaBusy rises at T+1, first RD at 0xC000.
  - Exactly 160 writes occur, to 0xFE00–0xFE9F, each with matching data.
  - oDmaBusy falls after cycle T+320.
  - oDmaReg=0xC0 throughout.
- Lockout: during DMA, CPU reads 0xC000 -> 0xFF; CPU writes 0x11 to 0xD000 -> no memory write to 0xD000; reading 0xFF46 returns 0xC0.
- Restart: DMA from 0xC0 running; at byte index 50, during its WR cycle, CPU writes 0xD0 to 0xFF46.
  - That WR still writes 0xFE32.
  - The next cycle is RD at 0xD000.
  - Then 160 full bytes are copied from 0xD000.
- Reset mid-transfer: assert iReset at byte 80 -> from the next cycle oMemWe=0, oDmaBusy=0, oDmaReg=0x00, pass-through resumes.
- Boundary: source 0xFF, DMA_LEN=160 -> reads 0xFF00–0xFF9F in order. Separately with DMA_LEN=256, OAM_BASE=16'hFFF0 -> destination wraps 0xFFFF->0x0000, and the source index does not carry into the high byte.
